unary_gates: RTL and testbench
==============================

UNARY_GATES -- requirements
Module: unary_gates

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 1, bit width of operand a (legal range 1..64).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port a, input, WIDTH bits: unsigned operand, sampled every rising clk edge.
REQ-005 The block SHALL have port not_out, output, WIDTH bits: registered bitwise NOT of a.
REQ-006 The block SHALL have port pos_out, output, WIDTH bits: registered unary plus of a (a unchanged).
REQ-007 The block SHALL have port neg_out, output, WIDTH bits: registered two's-complement negation of a.
REQ-008 The block SHALL have port reduce_and_out, output, 1 bit: registered AND of all bits of a.
REQ-009 The block SHALL have port reduce_or_out, output, 1 bit: registered OR of all bits of a.
REQ-010 The block SHALL have port reduce_xor_out, output, 1 bit: registered XOR (odd parity) of all bits of a.
REQ-011 The block SHALL have port reduce_xnor_out, output, 1 bit: registered XNOR (even parity) of all bits of a.
REQ-012 The block SHALL have port logic_not_out, output, 1 bit: registered logical NOT of a (1 iff a == 0).

Function
REQ-013 Every output SHALL be a flip-flop output; no combinational path from a to any output.
REQ-014 Latency SHALL be exactly one clk cycle: outputs after rising edge N reflect a sampled at edge N.
REQ-015 Outputs SHALL update on every rising edge with rst_n high; no enable, no handshake, no hold state.
REQ-016 neg_out SHALL equal (~a + 1) truncated to WIDTH bits; carry discarded; neg_out of 0 = 0; neg_out of 2^(WIDTH-1) = 2^(WIDTH-1).
REQ-017 For WIDTH = 1: neg_out = a; pos_out = a; reduce_and/or/xor_out = a; reduce_xnor_out = logic_not_out = not_out = ~a.
REQ-018 Invariants: reduce_xnor_out == ~reduce_xor_out; logic_not_out == ~reduce_or_out; not_out == ~pos_out; pos_out + neg_out == 0 mod 2^WIDTH.
REQ-019 reduce_and_out SHALL be 1 only when a is all ones; reduce_or_out SHALL be 0 only when a is all zeros.
REQ-020 Any X/Z on a SHALL be outside contract; no X-handling logic is required.

Reset
REQ-021 rst_n low SHALL immediately, without waiting for clk, force all outputs to 0 (including logic_not_out and reduce_xnor_out).
REQ-022 While rst_n is low, outputs SHALL stay 0 regardless of a and clk.
REQ-023 Reset release SHALL be synchronised by design intent only; the first rising edge with rst_n high SHALL load results for the a sampled at that edge.
REQ-024 Reset asserted mid-operation SHALL discard the pending result; no stale value SHALL appear after release.

Verification
REQ-025 WIDTH=1, rst_n low -> all outputs 0 asynchronously, with no clk edge needed.
REQ-026 WIDTH=1, a=0, one edge -> not_out=1, pos_out=0, neg_out=0, reduce_and=0, reduce_or=0, reduce_xor=0, reduce_xnor=1, logic_not=1.
REQ-027 WIDTH=1, a=1, one edge -> not_out=0, pos_out=1, neg_out=1, reduce_and=1, reduce_or=1, reduce_xor=1, reduce_xnor=0, logic_not=0.
REQ-028 WIDTH=8, a=0x80 -> neg_out=0x80; a=0x01 -> neg_out=0xFF, not_out=0xFE, reduce_xor=1; a=0xFF -> reduce_and=1, reduce_xnor=1.
REQ-029 WIDTH=8, change a between edges -> outputs change only at the next rising edge, exactly one cycle after sampling.
REQ-030 WIDTH=8, a=0xA5 then rst_n pulsed low mid-cycle -> outputs drop to 0 at once; after release the next edge shows results for the current a.

Source files
------------

// File: rtl/unary_gates.sv
// Registered unary operators on a WIDTH-bit operand: bitwise NOT, plus, negation,
// the four reductions and logical NOT, all with one cycle of latency.
module unary_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] not_out,
  output logic [WIDTH-1:0] pos_out,
  output logic [WIDTH-1:0] neg_out,
  output logic             reduce_and_out,
  output logic             reduce_or_out,
  output logic             reduce_xor_out,
  output logic             reduce_xnor_out,
  output logic             logic_not_out
);

  function automatic logic odd_parity(input logic [WIDTH-1:0] v);
    logic p;
    p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      p = p ^ v[i];
    end
    return p;
  endfunction

  logic [WIDTH-1:0] not_d, not_q;
  logic [WIDTH-1:0] pos_d, pos_q;
  logic [WIDTH-1:0] neg_d, neg_q;
  logic             rand_d, rand_q;
  logic             ror_d, ror_q;
  logic             rxor_d, rxor_q;
  logic             rxnor_d, rxnor_q;
  logic             lnot_d, lnot_q;

  // Next-state results for the operand presented this cycle.
  always_comb begin
    not_d   = ~a;
    pos_d   = a;
    neg_d   = {WIDTH{1'b0}} - a;
    rand_d  = &a;
    ror_d   = |a;
    rxor_d  = odd_parity(a);
    rxnor_d = ~odd_parity(a);
    lnot_d  = ~(|a);
  end

  // Result registers; reset clears every output, including the active-high-at-zero ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      not_q   <= {WIDTH{1'b0}};
      pos_q   <= {WIDTH{1'b0}};
      neg_q   <= {WIDTH{1'b0}};
      rand_q  <= 1'b0;
      ror_q   <= 1'b0;
      rxor_q  <= 1'b0;
      rxnor_q <= 1'b0;
      lnot_q  <= 1'b0;
    end else begin
      not_q   <= not_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      rand_q  <= rand_d;
      ror_q   <= ror_d;
      rxor_q  <= rxor_d;
      rxnor_q <= rxnor_d;
      lnot_q  <= lnot_d;
    end
  end

  assign not_out         = not_q;
  assign pos_out         = pos_q;
  assign neg_out         = neg_q;
  assign reduce_and_out  = rand_q;
  assign reduce_or_out   = ror_q;
  assign reduce_xor_out  = rxor_q;
  assign reduce_xnor_out = rxnor_q;
  assign logic_not_out   = lnot_q;

endmodule

// File: tb/tb_unary_gates.sv
// Directed and random checks of unary_gates at WIDTH=1 and WIDTH=8 against an arithmetic model.
module tb_unary_gates;

  logic       clk;
  logic       rst_n;
  logic [0:0] a1;
  logic [7:0] a8;

  logic [0:0] n1_not, n1_pos, n1_neg;
  logic       n1_and, n1_or, n1_xor, n1_xnor, n1_lnot;
  logic [7:0] n8_not, n8_pos, n8_neg;
  logic       n8_and, n8_or, n8_xor, n8_xnor, n8_lnot;

  int total = 0;
  int bad   = 0;

  unary_gates #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1),
    .not_out(n1_not), .pos_out(n1_pos), .neg_out(n1_neg),
    .reduce_and_out(n1_and), .reduce_or_out(n1_or),
    .reduce_xor_out(n1_xor), .reduce_xnor_out(n1_xnor),
    .logic_not_out(n1_lnot)
  );

  unary_gates #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8),
    .not_out(n8_not), .pos_out(n8_pos), .neg_out(n8_neg),
    .reduce_and_out(n8_and), .reduce_or_out(n8_or),
    .reduce_xor_out(n8_xor), .reduce_xnor_out(n8_xnor),
    .logic_not_out(n8_lnot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int popcount(input int unsigned v);
    int c;
    c = 0;
    while (v != 0) begin
      c += v % 2;
      v  = v / 2;
    end
    return c;
  endfunction

  // Model: values computed from the operator definitions with integer arithmetic.
  task automatic expect_w(input string tag, input int unsigned w, input int unsigned av);
    int unsigned m, ex_not, ex_neg, ex_par;
    m      = (32'd1 << w);
    ex_not = (m - 1) - av;
    ex_neg = (m - av) % m;
    ex_par = popcount(av) % 2;
    if (w == 1) begin
      chk({tag, ".w1.not"},  64'(n1_not),  64'(ex_not));
      chk({tag, ".w1.pos"},  64'(n1_pos),  64'(av));
      chk({tag, ".w1.neg"},  64'(n1_neg),  64'(ex_neg));
      chk({tag, ".w1.and"},  64'(n1_and),  64'(av == m - 1));
      chk({tag, ".w1.or"},   64'(n1_or),   64'(av != 0));
      chk({tag, ".w1.xor"},  64'(n1_xor),  64'(ex_par));
      chk({tag, ".w1.xnor"}, 64'(n1_xnor), 64'(1 - ex_par));
      chk({tag, ".w1.lnot"}, 64'(n1_lnot), 64'(av == 0));
    end else begin
      chk({tag, ".w8.not"},  64'(n8_not),  64'(ex_not));
      chk({tag, ".w8.pos"},  64'(n8_pos),  64'(av));
      chk({tag, ".w8.neg"},  64'(n8_neg),  64'(ex_neg));
      chk({tag, ".w8.and"},  64'(n8_and),  64'(av == m - 1));
      chk({tag, ".w8.or"},   64'(n8_or),   64'(av != 0));
      chk({tag, ".w8.xor"},  64'(n8_xor),  64'(ex_par));
      chk({tag, ".w8.xnor"}, 64'(n8_xnor), 64'(1 - ex_par));
      chk({tag, ".w8.lnot"}, 64'(n8_lnot), 64'(av == 0));
    end
  endtask

  task automatic expect_zero(input string tag);
    chk({tag, ".w1.all"}, 64'({n1_not, n1_pos, n1_neg, n1_and, n1_or, n1_xor, n1_xnor, n1_lnot}), 64'd0);
    chk({tag, ".w8.vec"}, 64'({n8_not, n8_pos, n8_neg}), 64'd0);
    chk({tag, ".w8.bit"}, 64'({n8_and, n8_or, n8_xor, n8_xnor, n8_lnot}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a1    = 1'b1;
    a8    = 8'h00;
    #2;
    expect_zero("por");

    // Release away from the edge; first edge loads the sampled operand.
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b0;
    a8 = 8'h80;
    @(posedge clk); #1;
    expect_w("a0_x80", 1, 0);
    expect_w("a0_x80", 8, 32'h80);

    @(negedge clk);
    a1 = 1'b1;
    a8 = 8'h01;
    @(posedge clk); #1;
    expect_w("a1_x01", 1, 1);
    expect_w("a1_x01", 8, 32'h01);

    @(negedge clk);
    a8 = 8'hFF;
    @(posedge clk); #1;
    expect_w("xff", 8, 32'hFF);

    @(negedge clk);
    a8 = 8'h00;
    @(posedge clk); #1;
    expect_w("x00", 8, 32'h00);

    // Operand changes between edges must not reach the outputs early.
    @(negedge clk);
    a8 = 8'h5A;
    @(posedge clk); #1;
    expect_w("x5a", 8, 32'h5A);
    #2;
    a8 = 8'hC3;
    #1;
    expect_w("hold_x5a", 8, 32'h5A);
    @(posedge clk); #1;
    expect_w("xc3", 8, 32'hC3);

    // Mid-cycle reset pulse clears at once, holds through edges, then no stale data.
    @(negedge clk);
    a8 = 8'hA5;
    @(posedge clk); #1;
    expect_w("xa5", 8, 32'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    expect_zero("async_rst");
    @(posedge clk); #1;
    expect_zero("rst_hold");
    a8 = 8'h3C;
    a1 = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    expect_zero("rel_no_edge");
    @(posedge clk); #1;
    expect_w("after_rel", 8, 32'h3C);
    expect_w("after_rel", 1, 0);

    for (int i = 0; i < 40; i++) begin
      int unsigned r8, r1;
      @(negedge clk);
      r8 = $urandom_range(255, 0);
      r1 = $urandom_range(1, 0);
      a8 = r8[7:0];
      a1 = r1[0:0];
      @(posedge clk); #1;
      expect_w("rnd", 8, r8);
      expect_w("rnd", 1, r1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
